fir_serial_mc: RTL

FIR_SERIAL_MC -- requirements
Module: fir_serial_mc

---
 rtl/fir_pkg.sv | 61 ++++++
 rtl/fir_mac.sv | 65 ++++++
 rtl/fir_serial_mc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial multi-channel FIR filter.
//   state_e    : controller states (idle / multiply-accumulate / output)
//   round_shr  : round-half-up arithmetic right shift
//   sat_max    : largest value of a signed field of a given width
//   sat_hit    : value lies outside a signed field of a given width
//   sat_clamp  : clamp a value into a signed field of a given width
// All helpers work on a wide fixed-size signed word so callers sign-extend
// into it and size-cast the result back to their own width.
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_e;

    localparam int unsigned MaxW = 128;

    // (v + 2^(shift-1)) >>> shift; shift must be at least 1.
    function automatic logic signed [MaxW-1:0] round_shr(input logic signed [MaxW-1:0] v,
                                                         input int unsigned shift);
        logic signed [MaxW-1:0] half;
        half = '0;
        half[shift-1] = 1'b1;
        return (v + half) >>> shift;
    endfunction

    function automatic logic signed [MaxW-1:0] sat_max(input int unsigned width);
        logic signed [MaxW-1:0] one;
        one = {{(MaxW-1){1'b0}}, 1'b1};
        return (one <<< (width - 1)) - one;
    endfunction

    function automatic logic sat_hit(input logic signed [MaxW-1:0] v,
                                     input int unsigned width);
        logic signed [MaxW-1:0] one;
        logic signed [MaxW-1:0] hi;
        logic signed [MaxW-1:0] lo;
        one = {{(MaxW-1){1'b0}}, 1'b1};
        hi  = sat_max(width);
        lo  = -hi - one;
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [MaxW-1:0] sat_clamp(input logic signed [MaxW-1:0] v,
                                                         input int unsigned width);
        logic signed [MaxW-1:0] one;
        logic signed [MaxW-1:0] hi;
        logic signed [MaxW-1:0] lo;
        one = {{(MaxW-1){1'b0}}, 1'b1};
        hi  = sat_max(width);
        lo  = -hi - one;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath of the serial FIR.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : zero the accumulator (takes priority over en_i)
//   en_i         : add data_i * coef_i to the accumulator
//   data_i       : signed sample
//   coef_i       : signed Q1.(WIDTH_COEFF-1) coefficient
//   out_data_o   : accumulator rounded half-up, shifted back to sample scale, saturated
//   out_sat_o    : saturation clamped out_data_o
module fir_mac
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH_DATA  = 24,
    parameter int unsigned WIDTH_COEFF = 16,
    parameter int unsigned WIDTH_ACC   = 45
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          en_i,
    input  logic signed [WIDTH_DATA-1:0]  data_i,
    input  logic signed [WIDTH_COEFF-1:0] coef_i,
    output logic signed [WIDTH_DATA-1:0]  out_data_o,
    output logic                          out_sat_o
);

    localparam int unsigned ProdW = WIDTH_DATA + WIDTH_COEFF;

    logic signed [WIDTH_ACC-1:0] acc_q;
    logic signed [WIDTH_ACC-1:0] acc_d;
    logic signed [ProdW-1:0]     prod;
    logic signed [MaxW-1:0]      acc_ext;
    logic signed [MaxW-1:0]      rounded;

    // Operands are sign-extended to the full product width so the low ProdW
    // bits of the product are the exact two's-complement result.
    always_comb begin
        prod = $signed({{WIDTH_COEFF{data_i[WIDTH_DATA-1]}}, data_i})
             * $signed({{WIDTH_DATA{coef_i[WIDTH_COEFF-1]}}, coef_i});
    end

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(WIDTH_ACC-ProdW){prod[ProdW-1]}}, prod};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        acc_ext    = {{(MaxW-WIDTH_ACC){acc_q[WIDTH_ACC-1]}}, acc_q};
        rounded    = round_shr(acc_ext, WIDTH_COEFF - 1);
        out_data_o = WIDTH_DATA'(sat_clamp(rounded, WIDTH_DATA));
        out_sat_o  = sat_hit(rounded, WIDTH_DATA);
    end

endmodule

// File: rtl/fir_serial_mc.sv
// Serial multi-channel FIR filter: one shared multiplier-accumulator walks all
// TAP taps of one channel per accepted sample. Each channel keeps its own
// circular delay line and write pointer; all channels share one coefficient set.
//   clk, reset                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_chan : sample input handshake
//   coef_we/coef_addr/coef_data     : coefficient write port (honoured in idle only)
//   out_valid/out_ready/out_data/out_chan/out_sat : result handshake
module fir_serial_mc
    import fir_pkg::*;
#(
    parameter int unsigned  WIDTH_DATA  = 24,
    parameter int unsigned  WIDTH_COEFF = 16,
    parameter int unsigned  TAP         = 32,
    parameter int unsigned  CHANNELS    = 2,
    localparam int unsigned WIDTH_ACC   = WIDTH_DATA + WIDTH_COEFF + $clog2(TAP),
    localparam int unsigned WIDTH_CHAN  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned WIDTH_ADDR  = $clog2(TAP)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WIDTH_DATA-1:0]  in_data,
    input  logic [WIDTH_CHAN-1:0]         in_chan,
    input  logic                          coef_we,
    input  logic [WIDTH_ADDR-1:0]         coef_addr,
    input  logic signed [WIDTH_COEFF-1:0] coef_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH_DATA-1:0]  out_data,
    output logic [WIDTH_CHAN-1:0]         out_chan,
    output logic                          out_sat
);

    localparam logic [WIDTH_ADDR-1:0] LastTap = WIDTH_ADDR'(TAP - 1);
    localparam logic [WIDTH_ADDR:0]   TapWide = (WIDTH_ADDR + 1)'(TAP);

    state_e                  state_q, state_d;
    logic [WIDTH_ADDR-1:0]   k_q, k_d;
    logic [WIDTH_ADDR-1:0]   newest_q, newest_d;
    logic [WIDTH_CHAN-1:0]   chan_q, chan_d;

    logic [WIDTH_ADDR-1:0]   wp_q [CHANNELS];
    logic signed [WIDTH_DATA-1:0]  dl_q [CHANNELS][TAP];
    logic signed [WIDTH_COEFF-1:0] coef_q [TAP];

    logic                    chan_ok;
    logic                    accept;
    logic                    coef_wr;
    logic                    mac_clear;
    logic                    mac_en;
    logic [WIDTH_ADDR-1:0]   wp_next;
    logic [WIDTH_ADDR:0]     rd_sum;
    logic [WIDTH_ADDR-1:0]   rd_idx;

    always_comb begin
        chan_ok   = {{(32-WIDTH_CHAN){1'b0}}, in_chan} < CHANNELS;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StOut);
        accept    = in_ready && in_valid && chan_ok;
        coef_wr   = in_ready && coef_we;
        wp_next   = (wp_q[in_chan] == LastTap) ? '0 : wp_q[in_chan] + 1'b1;
    end

    // Tap k reads x[n-k], i.e. the slot k positions behind the newest sample,
    // wrapping modulo TAP (which need not be a power of two).
    always_comb begin
        rd_sum = {1'b0, newest_q} + TapWide - {1'b0, k_q};
        rd_idx = (rd_sum >= TapWide) ? WIDTH_ADDR'(rd_sum - TapWide) : rd_sum[WIDTH_ADDR-1:0];
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        newest_d  = newest_q;
        chan_d    = chan_q;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StMac;
                    k_d       = '0;
                    newest_d  = wp_q[in_chan];
                    chan_d    = in_chan;
                    mac_clear = 1'b1;
                end
            end
            StMac: begin
                mac_en = 1'b1;
                if (k_q == LastTap) begin
                    state_d = StOut;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            newest_q <= '0;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            newest_q <= newest_d;
            chan_q   <= chan_d;
        end
    end

    // A coefficient written in the accepting cycle lands before the first MAC
    // cycle reads it, so that computation already uses the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                wp_q[c] <= '0;
                for (int t = 0; t < int'(TAP); t++) begin
                    dl_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < int'(TAP); t++) begin
                coef_q[t] <= '0;
            end
        end else begin
            if (accept) begin
                dl_q[in_chan][wp_q[in_chan]] <= in_data;
                wp_q[in_chan]                <= wp_next;
            end
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    fir_mac #(
        .WIDTH_DATA  (WIDTH_DATA),
        .WIDTH_COEFF (WIDTH_COEFF),
        .WIDTH_ACC   (WIDTH_ACC)
    ) u_mac (
        .clk_i      (clk),
        .rst_i      (reset),
        .clear_i    (mac_clear),
        .en_i       (mac_en),
        .data_i     (dl_q[chan_q][rd_idx]),
        .coef_i     (coef_q[k_q]),
        .out_data_o (out_data),
        .out_sat_o  (out_sat)
    );

    assign out_chan = chan_q;

endmodule
